// File: rtl/udp_payload_framer.sv
// Splits an AXI-stream byte message into UDP payload frames of at most MAX_PAYLOAD
// bytes, buffering data in a circular byte store and queueing segment lengths.
//
// state | meaning
// IDLE  | waiting for a queued segment length
// SEND  | streaming the latched segment out of the buffer
// GAP   | inter-frame idle countdown
module udp_payload_framer #(
    parameter int MAX_PAYLOAD = 1472,
    parameter int FIFO_DEPTH  = 2048,
    parameter int IFG_CYCLES  = 12
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    input  logic        m_axis_tready,
    output logic [15:0] UDP_TotLen,
    output logic [15:0] IP_TotLen,
    output logic        busy
);

    localparam int              AW        = $clog2(FIFO_DEPTH);
    localparam int              CW        = AW + 1;
    localparam int              GW        = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [AW-1:0]   PTR_ONE   = AW'(1);
    localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]   DEPTH_CNT = CW'(FIFO_DEPTH);
    localparam logic [15:0]     MAX_LEN   = 16'(MAX_PAYLOAD);
    localparam logic [GW-1:0]   GAP_ONE   = GW'(1);
    localparam logic [GW-1:0]   GAP_LOAD  = (IFG_CYCLES > 0) ? GW'(IFG_CYCLES - 1) : '0;

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t        state, state_nxt;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] data_cnt;
    logic [15:0]   seg_cnt, seg_next;
    logic [15:0]   len_q [4];
    logic [1:0]    lq_wr, lq_rd;
    logic [2:0]    lq_cnt;
    logic          ready_en;
    logic          wr_en, rd_en, lq_push, lq_pop, last_hs;
    logic [15:0]   rem_cnt;
    logic [GW-1:0] gap_cnt;

    // ready_en keeps tready low through reset and lifts it on the first edge after release
    assign s_axis_tready = ready_en && (data_cnt != DEPTH_CNT) && (lq_cnt != 3'd4);
    assign wr_en         = s_axis_tvalid && s_axis_tready;
    assign seg_next      = seg_cnt + 16'd1;
    assign lq_push       = wr_en && (s_axis_tlast || (seg_next == MAX_LEN));

    assign m_axis_tvalid = (state == SEND);
    assign m_axis_tlast  = (state == SEND) && (rem_cnt == 16'd1);
    assign m_axis_tdata  = m_axis_tvalid ? mem[rd_ptr] : 8'h00;
    assign m_axis_tuser  = 1'b0;
    assign busy          = (state != IDLE);
    assign rd_en         = m_axis_tvalid && m_axis_tready;
    assign last_hs       = rd_en && (rem_cnt == 16'd1);

    always_ff @(posedge sys_clk) begin
        if (wr_en) mem[wr_ptr] <= s_axis_tdata;
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en <= 1'b0;
            wr_ptr   <= '0;
            data_cnt <= '0;
            seg_cnt  <= '0;
            lq_wr    <= '0;
            lq_rd    <= '0;
            lq_cnt   <= '0;
            for (int i = 0; i < 4; i++) len_q[i] <= '0;
        end else begin
            ready_en <= 1'b1;
            if (wr_en) begin
                wr_ptr  <= wr_ptr + PTR_ONE;
                seg_cnt <= lq_push ? 16'd0 : seg_next;
            end
            case ({wr_en, rd_en})
                2'b10:   data_cnt <= data_cnt + CNT_ONE;
                2'b01:   data_cnt <= data_cnt - CNT_ONE;
                default: data_cnt <= data_cnt;
            endcase
            if (lq_push) begin
                len_q[lq_wr] <= seg_next;
                lq_wr        <= lq_wr + 2'd1;
            end
            if (lq_pop) lq_rd <= lq_rd + 2'd1;
            case ({lq_push, lq_pop})
                2'b10:   lq_cnt <= lq_cnt + 3'd1;
                2'b01:   lq_cnt <= lq_cnt - 3'd1;
                default: lq_cnt <= lq_cnt;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        lq_pop    = 1'b0;
        case (state)
            IDLE: begin
                if (lq_cnt != 3'd0) begin
                    lq_pop    = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND:    if (last_hs) state_nxt = GAP;
            GAP:     if (gap_cnt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rd_ptr     <= '0;
            rem_cnt    <= '0;
            gap_cnt    <= '0;
            UDP_TotLen <= '0;
            IP_TotLen  <= '0;
        end else begin
            state <= state_nxt;
            if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
            if (lq_pop) begin
                rem_cnt    <= len_q[lq_rd];
                UDP_TotLen <= len_q[lq_rd] + 16'd8;
                IP_TotLen  <= len_q[lq_rd] + 16'd28;
            end else if (rd_en) begin
                rem_cnt <= rem_cnt - 16'd1;
            end
            // GAP always lasts GAP_LOAD+1 cycles; terminal count is zero
            if (last_hs)
                gap_cnt <= GAP_LOAD;
            else if ((state == GAP) && (gap_cnt != '0))
                gap_cnt <= gap_cnt - GAP_ONE;
        end
    end

endmodule

// File: tb/tb_udp_payload_framer.sv
// Directed and randomized checks of udp_payload_framer against a byte-stream
// segmentation model kept in queues.
module tb_udp_payload_framer;

    localparam int MAX_PAYLOAD = 1472;
    localparam int FIFO_DEPTH  = 2048;
    localparam int IFG_CYCLES  = 12;

    logic        sys_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic [7:0]  s_axis_tdata  = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tlast  = 1'b0;
    logic        s_axis_tready;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        m_axis_tready = 1'b0;
    logic [15:0] UDP_TotLen;
    logic [15:0] IP_TotLen;
    logic        busy;

    udp_payload_framer #(
        .MAX_PAYLOAD(MAX_PAYLOAD),
        .FIFO_DEPTH (FIFO_DEPTH),
        .IFG_CYCLES (IFG_CYCLES)
    ) dut (
        .sys_clk      (sys_clk),
        .rst_n        (rst_n),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tuser (m_axis_tuser),
        .m_axis_tready(m_axis_tready),
        .UDP_TotLen   (UDP_TotLen),
        .IP_TotLen    (IP_TotLen),
        .busy         (busy)
    );

    initial forever #5 sys_clk = ~sys_clk;

    int checks = 0;
    int failures = 0;

    // reference model: bytes offered, expected frame lengths, open segment size
    logic [8:0] in_q[$];
    logic [7:0] exp_bytes[$];
    int         exp_lens[$];
    int         model_seg = 0;

    logic [7:0] rx_bytes[$];
    int         rx_lens[$];
    int         rx_udp[$];
    int         rx_ip[$];
    int         cur_len = 0;
    logic [15:0] cur_udp = '0, cur_ip = '0;

    logic       prev_stall = 1'b0, prev_valid = 1'b0, prev_last = 1'b0;
    logic [7:0] prev_data = '0;
    int         gap_cnt = 1000;
    int         cyc = 0, last_bnd_cyc = 0, latency = 0, acc_cnt = 0;
    int         valid_pct = 100, ready_pct = 100;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic add_bytes(input int n, input bit with_last, input bit incr, input logic [7:0] base);
        logic [7:0] d;
        logic       l;
        for (int i = 0; i < n; i++) begin
            d = incr ? 8'(int'(base) + i) : 8'($urandom_range(0, 255));
            l = with_last && (i == n - 1);
            in_q.push_back({l, d});
            exp_bytes.push_back(d);
            model_seg++;
            if (l || model_seg == MAX_PAYLOAD) begin
                exp_lens.push_back(model_seg);
                model_seg = 0;
            end
        end
    endtask

    task automatic clear_all();
        in_q.delete(); exp_bytes.delete(); exp_lens.delete();
        rx_bytes.delete(); rx_lens.delete(); rx_udp.delete(); rx_ip.delete();
        model_seg = 0;
        cur_len = 0;
    endtask

    task automatic sample();
        cyc++;
        if (s_axis_tvalid && s_axis_tready) begin
            void'(in_q.pop_front());
            acc_cnt++;
            if (s_axis_tlast) last_bnd_cyc = cyc;
        end
        if (prev_stall) begin
            check("hold_valid", m_axis_tvalid, 1);
            check("hold_data", m_axis_tdata, prev_data);
            check("hold_last", m_axis_tlast, prev_last);
        end
        if (m_axis_tvalid && !prev_valid) latency = cyc - last_bnd_cyc;
        if (m_axis_tvalid && m_axis_tready) begin
            if (cur_len == 0) begin
                check("ifg_min", gap_cnt >= IFG_CYCLES, 1);
                cur_udp = UDP_TotLen;
                cur_ip  = IP_TotLen;
            end else begin
                check("udp_stable", UDP_TotLen, cur_udp);
                check("ip_stable", IP_TotLen, cur_ip);
            end
            check("tuser", m_axis_tuser, 0);
            rx_bytes.push_back(m_axis_tdata);
            cur_len++;
            if (m_axis_tlast) begin
                rx_lens.push_back(cur_len);
                rx_udp.push_back(int'(cur_udp));
                rx_ip.push_back(int'(cur_ip));
                cur_len = 0;
                gap_cnt = 0;
            end
        end else if (!m_axis_tvalid) begin
            gap_cnt++;
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_valid = m_axis_tvalid;
        prev_data  = m_axis_tdata;
        prev_last  = m_axis_tlast;
    endtask

    task automatic cycle();
        @(posedge sys_clk);
        #1;
        if (in_q.size() > 0 && int'($urandom_range(0, 99)) < valid_pct) begin
            s_axis_tvalid = 1'b1;
            {s_axis_tlast, s_axis_tdata} = in_q[0];
        end else begin
            s_axis_tvalid = 1'b0;
            s_axis_tlast  = 1'b0;
            s_axis_tdata  = '0;
        end
        m_axis_tready = int'($urandom_range(0, 99)) < ready_pct;
        @(negedge sys_clk);
        sample();
    endtask

    task automatic run_until_done(input int budget);
        int n = 0;
        while ((in_q.size() > 0 || rx_bytes.size() < exp_bytes.size() || cur_len != 0) && n < budget) begin
            cycle();
            n++;
        end
        check("no_timeout", n < budget, 1);
        repeat (30) cycle();
    endtask

    task automatic compare_frames(input string name);
        int nf, nb, mism;
        check({name, "_frames"}, rx_lens.size(), exp_lens.size());
        check({name, "_bytes"}, rx_bytes.size(), exp_bytes.size());
        nf = (rx_lens.size() < exp_lens.size()) ? rx_lens.size() : exp_lens.size();
        for (int i = 0; i < nf; i++) begin
            check({name, "_len"}, rx_lens[i], exp_lens[i]);
            check({name, "_udp"}, rx_udp[i], exp_lens[i] + 8);
            check({name, "_ip"}, rx_ip[i], exp_lens[i] + 28);
        end
        nb = (rx_bytes.size() < exp_bytes.size()) ? rx_bytes.size() : exp_bytes.size();
        mism = 0;
        for (int i = 0; i < nb; i++) if (rx_bytes[i] !== exp_bytes[i]) mism++;
        check({name, "_data_mismatches"}, mism, 0);
    endtask

    task automatic apply_reset();
        @(negedge sys_clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_s_tready", s_axis_tready, 0);
        check("rst_m_tvalid", m_axis_tvalid, 0);
        check("rst_m_tlast", m_axis_tlast, 0);
        check("rst_m_tuser", m_axis_tuser, 0);
        check("rst_busy", busy, 0);
        check("rst_m_tdata", m_axis_tdata, 0);
        check("rst_udp", UDP_TotLen, 0);
        check("rst_ip", IP_TotLen, 0);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = '0;
        clear_all();
        prev_stall = 1'b0;
        prev_valid = 1'b0;
        gap_cnt    = 1000;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        #2;
        rst_n = 1'b1;
        #1;
        check("tready_before_edge", s_axis_tready, 0);
        @(posedge sys_clk);
        #1;
        check("tready_after_edge", s_axis_tready, 1);
    endtask

    initial begin
        int n;

        apply_reset();

        // ten incrementing bytes, one frame
        valid_pct = 100; ready_pct = 100;
        add_bytes(10, 1'b1, 1'b1, 8'h00);
        run_until_done(500);
        if (rx_lens.size() > 0) begin
            check("ten_len", rx_lens[0], 10);
            check("ten_udp", rx_udp[0], 18);
            check("ten_ip", rx_ip[0], 38);
        end
        compare_frames("ten");
        clear_all();

        // single byte from idle: latency and minimal frame
        add_bytes(1, 1'b1, 1'b1, 8'hA5);
        run_until_done(200);
        check("one_latency", latency, 2);
        if (rx_lens.size() > 0) begin
            check("one_udp", rx_udp[0], 9);
            check("one_ip", rx_ip[0], 29);
            check("one_data", rx_bytes[0], 8'hA5);
        end
        compare_frames("one");
        clear_all();

        // tlast exactly on the MAX_PAYLOAD-th byte
        valid_pct = 80; ready_pct = 80;
        add_bytes(MAX_PAYLOAD, 1'b1, 1'b0, 8'h00);
        run_until_done(6000);
        check("max_nframes", rx_lens.size(), 1);
        compare_frames("max");
        clear_all();

        // 3000-byte message split across three frames
        valid_pct = 75; ready_pct = 75;
        add_bytes(3000, 1'b1, 1'b0, 8'h00);
        run_until_done(12000);
        if (rx_lens.size() == 3) begin
            check("big_len2", rx_lens[2], 56);
            check("big_udp0", rx_udp[0], 1480);
            check("big_udp1", rx_udp[1], 1480);
            check("big_udp2", rx_udp[2], 64);
        end
        compare_frames("big");
        clear_all();

        // partial segment is held until its tail arrives
        valid_pct = 100; ready_pct = 100;
        add_bytes(5, 1'b0, 1'b0, 8'h00);
        repeat (60) cycle();
        check("partial_no_output", rx_bytes.size(), 0);
        check("partial_tvalid", m_axis_tvalid, 0);
        add_bytes(7, 1'b1, 1'b0, 8'h00);
        run_until_done(300);
        compare_frames("partial");
        clear_all();

        // random messages with random handshakes
        valid_pct = 60; ready_pct = 60;
        for (int i = 0; i < 10; i++) add_bytes(int'($urandom_range(1, 300)), 1'b1, 1'b0, 8'h00);
        add_bytes(1600, 1'b1, 1'b0, 8'h00);
        run_until_done(20000);
        compare_frames("rand");
        clear_all();

        // downstream stalled: buffer fills to FIFO_DEPTH
        valid_pct = 100; ready_pct = 0;
        add_bytes(2100, 1'b1, 1'b0, 8'h00);
        acc_cnt = 0;
        repeat (2200) cycle();
        check("fill_accepted", acc_cnt, FIFO_DEPTH);
        check("fill_tready", s_axis_tready, 0);
        check("fill_tvalid", m_axis_tvalid, 1);
        ready_pct = 100;
        run_until_done(5000);
        compare_frames("fill");
        clear_all();

        // downstream stalled: length queue fills with four short messages
        ready_pct = 0;
        for (int i = 0; i < 6; i++) add_bytes(2, 1'b1, 1'b0, 8'h00);
        acc_cnt = 0;
        repeat (40) cycle();
        check("queue_accepted", acc_cnt, 10);
        check("queue_tready", s_axis_tready, 0);
        ready_pct = 100;
        run_until_done(1000);
        compare_frames("queue");
        clear_all();

        // reset while a frame is being sent
        valid_pct = 100; ready_pct = 50;
        add_bytes(200, 1'b1, 1'b0, 8'h00);
        n = 0;
        while (cur_len < 5 && n < 500) begin
            cycle();
            n++;
        end
        check("midframe_reached", cur_len >= 5, 1);
        check("midframe_busy", busy, 1);
        apply_reset();
        valid_pct = 100; ready_pct = 100;
        add_bytes(20, 1'b1, 1'b1, 8'h40);
        run_until_done(500);
        compare_frames("post_reset");
        clear_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/udp_payload_framer.md
UDP_PAYLOAD_FRAMER -- requirements
Module: udp_payload_framer

Interface
REQ-001 SHALL have parameter MAX_PAYLOAD, default 1472, maximum UDP payload bytes per frame (legal range 1..1472).
REQ-002 SHALL have parameter FIFO_DEPTH, default 2048, data buffer depth in bytes (power of two, at least MAX_PAYLOAD).
REQ-003 SHALL have parameter IFG_CYCLES, default 12, idle cycles enforced after each frame's last byte.
REQ-004 SHALL have port sys_clk, input, 1 bit: single clock for all logic; both AXI-stream sides run on it.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port s_axis_tdata, input, 8 bits: payload byte in.
REQ-007 SHALL have port s_axis_tvalid, input, 1 bit: input byte valid.
REQ-008 SHALL have port s_axis_tlast, input, 1 bit: marks the end of a user message.
REQ-009 SHALL have port s_axis_tready, output, 1 bit: input byte accepted when tvalid and tready are both high.
REQ-010 SHALL have port m_axis_tdata, output, 8 bits: payload byte out; this port feeds the MAC transmitter's s_axis.
REQ-011 SHALL have port m_axis_tvalid, output, 1 bit: output byte valid.
REQ-012 SHALL have port m_axis_tlast, output, 1 bit: marks the last payload byte of the frame.
REQ-013 SHALL have port m_axis_tuser, output, 1 bit: held at 0.
REQ-014 SHALL have port m_axis_tready, input, 1 bit: downstream accepts the byte.
REQ-015 SHALL have port UDP_TotLen, output, 16 bits: current frame payload length + 8.
REQ-016 SHALL have port IP_TotLen, output, 16 bits: current frame payload length + 28.
REQ-017 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-018 Write side SHALL store each accepted byte in a FIFO_DEPTH-byte circular buffer; both pointers wrap modulo FIFO_DEPTH.
REQ-019 Write side SHALL keep a byte counter for the current segment; a boundary occurs when an accepted byte has tlast=1 or the counter reaches MAX_PAYLOAD.
- tlast on the MAX_PAYLOAD-th byte SHALL create exactly one boundary.
- tlast on the first byte SHALL create a 1-byte segment.
REQ-020 Each boundary SHALL push the segment length (16 bits) into a 4-entry length queue and clear the counter to 0 in the same cycle.
REQ-021 s_axis_tready SHALL equal (data buffer not full) AND (length queue not full); the decision is registered-free and based on current occupancy.
- A byte SHALL be accepted even when a read happens in the same cycle.
- A boundary SHALL be pushed even when a queue pop happens in the same cycle; occupancy then stays unchanged.
REQ-022 Read FSM states SHALL be IDLE, SEND, GAP.
- IDLE -> SEND when the length queue is non-empty. On this transition: pop the queue, latch len, and register UDP_TotLen = len+8 and IP_TotLen = len+28.
- SEND: m_axis_tvalid = 1 with the buffer byte at the read pointer. The pointer advances on each handshake. m_axis_tlast = 1 on byte number len.
- SEND -> GAP on the handshake of the last byte.
- GAP: tvalid = 0 for IFG_CYCLES cycles, then -> IDLE.
REQ-023 UDP_TotLen and IP_TotLen SHALL stay stable from the first byte of a frame until the next IDLE->SEND transition.
REQ-024 m_axis_tdata, tvalid and tlast SHALL hold unchanged while tvalid=1 and tready=0.
REQ-025 Minimum latency SHALL be 2 cycles from the boundary-byte handshake to the first m_axis_tvalid.
REQ-026 A partial segment with no tlast SHALL never be emitted; it waits for further input.
REQ-027 Length arithmetic SHALL be unsigned 16-bit; for legal MAX_PAYLOAD no overflow can occur.

Reset
REQ-028 rst_n low SHALL asynchronously clear the following:
- FSM to IDLE;
- all pointers, counters and the length queue;
- s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tuser and busy to 0;
- m_axis_tdata, UDP_TotLen and IP_TotLen to 0.
REQ-029 Reset mid-frame SHALL discard all buffered data; after release, no stale byte is emitted.
REQ-030 s_axis_tready SHALL go high on the first clock edge after rst_n deasserts.

Verification
REQ-031 Send 10 bytes 0x00..0x09 with tlast on 0x09, tready=1.
-> One frame of 10 bytes, tlast on 0x09, UDP_TotLen=18, IP_TotLen=38.
REQ-032 With MAX_PAYLOAD=1472, send a 3000-byte message with tlast on the last byte.
-> Frames of 1472, 1472 and 56 bytes, each followed by at least 12 idle cycles. UDP_TotLen = 1480, 1480, 64.
REQ-033 Send tlast on the 1472nd byte.
-> Exactly one 1472-byte frame and no zero-length frame.
REQ-034 Hold m_axis_tready=0 while a continuous input stream runs.
-> s_axis_tready drops when the buffer holds FIFO_DEPTH bytes or the queue holds 4 lengths. No byte is lost or duplicated after tready resumes.
REQ-035 Send a single byte 0xA5 with tlast.
-> A 1-byte frame with tlast=1, UDP_TotLen=9, IP_TotLen=29.
REQ-036 Assert rst_n=0 during SEND, then release.
-> All outputs are 0 immediately. The next frame contains only post-reset data.
